kart_physics: RTL and testbench



---
 rtl/kart_physics.sv | 219 +++++++++++++++++++++
 tb/tb_kart_physics.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kart_physics.sv
// kart_physics: per-player motion engine for the split-screen racer.
//
// Once per frame tick the engine steers, updates speed, projects a candidate
// position along the new heading, probes the track map at that candidate and
// then commits or rejects the move. Position is held in Q10.6 map pixels.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   tick                  one-cycle frame pulse; ignored while busy
//   btn_accel/brake/      debounced button levels, latched on tick
//   btn_left/right
//   map_addr [16:0]       map read address (y*320 + x), registered
//   map_data [3:0]        map colour index, sampled one cycle after map_addr
//   world_x/world_y       committed integer position
//   degree [8:0]          committed heading 0..359 (0 = +X, 90 = +Y)
//   speed [7:0]           current speed, 1/64 px per frame
//   busy                  high while an update is in flight
module kart_physics #(
    parameter int unsigned START_X   = 40,
    parameter int unsigned START_Y   = 40,
    parameter int unsigned START_DEG = 0,
    parameter int unsigned MAX_SPEED = 192,
    parameter int unsigned GRASS_MAX = 64,
    parameter int unsigned ACCEL     = 4,
    parameter int unsigned BRAKE     = 8,
    parameter int unsigned TURN_STEP = 5,
    parameter logic [3:0]  WALL_IDX  = 4'd0,
    parameter logic [3:0]  GRASS_IDX = 4'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        btn_accel,
    input  logic        btn_brake,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [16:0] map_addr,
    input  logic [3:0]  map_data,
    output logic [9:0]  world_x,
    output logic [9:0]  world_y,
    output logic [8:0]  degree,
    output logic [7:0]  speed,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, STEER, TRIG, PROBE, WAIT, COMMIT} state_t;

    // round(127 * sin(k deg)) for k = 0..90
    localparam logic [6:0] SIN_TAB [0:90] = '{
        7'd0,   7'd2,   7'd4,   7'd7,   7'd9,   7'd11,  7'd13,  7'd15,  7'd18,  7'd20,
        7'd22,  7'd24,  7'd26,  7'd29,  7'd31,  7'd33,  7'd35,  7'd37,  7'd39,  7'd41,
        7'd43,  7'd46,  7'd48,  7'd50,  7'd52,  7'd54,  7'd56,  7'd58,  7'd60,  7'd62,
        7'd64,  7'd65,  7'd67,  7'd69,  7'd71,  7'd73,  7'd75,  7'd76,  7'd78,  7'd80,
        7'd82,  7'd83,  7'd85,  7'd87,  7'd88,  7'd90,  7'd91,  7'd93,  7'd94,  7'd96,
        7'd97,  7'd99,  7'd100, 7'd101, 7'd103, 7'd104, 7'd105, 7'd107, 7'd108, 7'd109,
        7'd110, 7'd111, 7'd112, 7'd113, 7'd114, 7'd115, 7'd116, 7'd117, 7'd118, 7'd119,
        7'd119, 7'd120, 7'd121, 7'd121, 7'd122, 7'd123, 7'd123, 7'd124, 7'd124, 7'd125,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127,
        7'd127
    };

    state_t             state, state_nx;
    logic [15:0]        pos_x, pos_y;
    logic signed [16:0] cand_x, cand_y;
    logic               lat_accel, lat_brake, lat_left, lat_right;
    logic               hit_wall, hit_grass;

    function automatic logic signed [7:0] q7(input logic [6:0] idx, input logic neg);
        logic signed [7:0] mag;
        mag = $signed({1'b0, SIN_TAB[idx]});
        return neg ? -mag : mag;
    endfunction

    // Quadrant folding of the quarter-wave table.
    function automatic logic signed [7:0] sin_q7(input logic [8:0] d);
        if (d <= 9'd90)       return q7(7'(d), 1'b0);
        else if (d <= 9'd180) return q7(7'(9'd180 - d), 1'b0);
        else if (d <= 9'd270) return q7(7'(d - 9'd180), 1'b1);
        else                  return q7(7'(9'd360 - d), 1'b1);
    endfunction

    function automatic logic signed [7:0] cos_q7(input logic [8:0] d);
        if (d <= 9'd90)       return q7(7'(9'd90 - d), 1'b0);
        else if (d <= 9'd180) return q7(7'(d - 9'd90), 1'b1);
        else if (d <= 9'd270) return q7(7'(9'd270 - d), 1'b1);
        else                  return q7(7'(d - 9'd270), 1'b0);
    endfunction

    // Heading step with wrap at 360; both or neither button leaves it alone.
    function automatic logic [8:0] steer_deg(input logic [8:0] d, input logic l, input logic r);
        logic [9:0] sum;
        sum = {1'b0, d};
        if (l && !r)
            sum = (d >= 9'(TURN_STEP)) ? sum - 10'(TURN_STEP) : sum + 10'(360 - TURN_STEP);
        else if (r && !l) begin
            sum = sum + 10'(TURN_STEP);
            if (sum >= 10'd360)
                sum = sum - 10'd360;
        end
        return 9'(sum);
    endfunction

    // Speed update with saturation at 0 and MAX_SPEED; brake has priority.
    function automatic logic [7:0] steer_speed(input logic [7:0] s, input logic acc, input logic brk);
        logic [8:0] up;
        up = {1'b0, s} + 9'(ACCEL);
        if (brk)
            return (s > 8'(BRAKE)) ? s - 8'(BRAKE) : 8'd0;
        if (acc)
            return (up > 9'(MAX_SPEED)) ? 8'(MAX_SPEED) : up[7:0];
        return (s != 8'd0) ? s - 8'd1 : 8'd0;
    endfunction

    // Displacement along the current heading, in 1/64 px (floor via >>>).
    logic signed [7:0]  cos_v, sin_v;
    logic signed [16:0] spd_s, cos_e, sin_e, prod_x, prod_y, dx, dy;
    assign cos_v  = cos_q7(degree);
    assign sin_v  = sin_q7(degree);
    assign spd_s  = $signed({9'd0, speed});
    assign cos_e  = {{9{cos_v[7]}}, cos_v};
    assign sin_e  = {{9{sin_v[7]}}, sin_v};
    assign prod_x = spd_s * cos_e;
    assign prod_y = spd_s * sin_e;
    assign dx     = prod_x >>> 7;
    assign dy     = prod_y >>> 7;

    // Candidate bounds check; a negative candidate shows up as the sign bit.
    logic [9:0]  cand_ix, cand_iy;
    logic        oob;
    logic [16:0] addr_calc;
    assign cand_ix   = cand_x[15:6];
    assign cand_iy   = cand_y[15:6];
    assign oob       = cand_x[16] | cand_y[16] | (cand_ix >= 10'd320) | (cand_iy >= 10'd240);
    assign addr_calc = 17'(cand_iy) * 17'd320 + 17'(cand_ix);

    assign world_x = pos_x[15:6];
    assign world_y = pos_y[15:6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tick) state_nx = STEER;
            STEER:   state_nx = TRIG;
            TRIG:    state_nx = PROBE;
            PROBE:   state_nx = oob ? COMMIT : WAIT;
            WAIT:    state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x     <= {10'(START_X), 6'b0};
            pos_y     <= {10'(START_Y), 6'b0};
            degree    <= 9'(START_DEG);
            speed     <= 8'd0;
            map_addr  <= 17'd0;
            busy      <= 1'b0;
            cand_x    <= '0;
            cand_y    <= '0;
            lat_accel <= 1'b0;
            lat_brake <= 1'b0;
            lat_left  <= 1'b0;
            lat_right <= 1'b0;
            hit_wall  <= 1'b0;
            hit_grass <= 1'b0;
        end else begin
            case (state)
                IDLE: if (tick) begin
                    lat_accel <= btn_accel;
                    lat_brake <= btn_brake;
                    lat_left  <= btn_left;
                    lat_right <= btn_right;
                    busy      <= 1'b1;
                end
                STEER: begin
                    degree <= steer_deg(degree, lat_left, lat_right);
                    speed  <= steer_speed(speed, lat_accel, lat_brake);
                end
                TRIG: begin
                    cand_x <= $signed({1'b0, pos_x}) + dx;
                    cand_y <= $signed({1'b0, pos_y}) + dy;
                end
                PROBE: begin
                    if (oob) begin
                        // Off the map behaves like a wall; the address is left alone.
                        hit_wall  <= 1'b1;
                        hit_grass <= 1'b0;
                    end else begin
                        map_addr <= addr_calc;
                    end
                end
                WAIT: begin
                    hit_wall  <= (map_data == WALL_IDX);
                    hit_grass <= (map_data == GRASS_IDX);
                end
                COMMIT: begin
                    if (hit_wall) begin
                        speed <= 8'd0;
                    end else begin
                        pos_x <= cand_x[15:0];
                        pos_y <= cand_y[15:0];
                        if (hit_grass && (speed > 8'(GRASS_MAX)))
                            speed <= 8'(GRASS_MAX);
                    end
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kart_physics.sv
// Scoreboard bench for kart_physics: a behavioural model predicts each frame
// update when a tick is issued; a monitor checks the outputs when busy falls.
module tb_kart_physics;

    localparam int START_X = 40;
    localparam int START_Y = 40;
    localparam int START_DEG = 0;
    localparam real PI = 3.14159265358979;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tick = 1'b0;
    logic        btn_accel = 1'b0, btn_brake = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [16:0] map_addr;
    logic [3:0]  map_data;
    logic [9:0]  world_x, world_y;
    logic [8:0]  degree;
    logic [7:0]  speed;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mode = 0;   // 0 track, 1 wall, 2 grass, 3 patchwork map

    typedef struct {int x; int y; int deg; int spd; int addr; int lat; int t0;} exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic busy_q = 1'b0;

    // Model state: position in 1/64 px, heading, speed, last probed address.
    int m_px, m_py, m_deg, m_spd, m_addr;
    bit m_oob;

    kart_physics dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .btn_accel(btn_accel), .btn_brake(btn_brake), .btn_left(btn_left), .btn_right(btn_right),
        .map_addr(map_addr), .map_data(map_data),
        .world_x(world_x), .world_y(world_y), .degree(degree), .speed(speed), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] terrain(input int a, input int m);
        int tx, ty, h;
        tx = (a % 320) / 8;
        ty = (a / 320) / 8;
        h = (tx * 7 + ty * 13 + tx * ty) % 16;
        case (m)
            0: return 4'd2;
            1: return 4'd0;
            2: return 4'd1;
            default: return (h == 0) ? 4'd0 : (h < 4) ? 4'd1 : 4'(2 + h % 5);
        endcase
    endfunction

    always_comb map_data = terrain(int'(map_addr), mode);

    function automatic int trig_q7(input int d, input bit want_sin);
        real a, v;
        a = d * PI / 180.0;
        v = want_sin ? $sin(a) : $cos(a);
        v = v * 127.0;
        if (v >= 0.0) return int'($floor(v + 0.5 + 1e-9));
        else          return -int'($floor(-v + 0.5 + 1e-9));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_px = START_X * 64; m_py = START_Y * 64; m_deg = START_DEG; m_spd = 0; m_addr = 0; m_oob = 0;
    endtask

    task automatic model_tick(input bit a, input bit b, input bit l, input bit r, input int t0);
        int dx, dy, cx, cy, ix, iy;
        logic [3:0] t;
        exp_t e;
        if (l && !r)      m_deg = (m_deg + 355) % 360;
        else if (r && !l) m_deg = (m_deg + 5) % 360;
        if (b)      m_spd = (m_spd > 8) ? m_spd - 8 : 0;
        else if (a) m_spd = (m_spd + 4 > 192) ? 192 : m_spd + 4;
        else if (m_spd > 0) m_spd = m_spd - 1;
        dx = (m_spd * trig_q7(m_deg, 1'b0)) >>> 7;
        dy = (m_spd * trig_q7(m_deg, 1'b1)) >>> 7;
        cx = m_px + dx; cy = m_py + dy;
        ix = cx >>> 6;  iy = cy >>> 6;
        m_oob = (cx < 0) || (cy < 0) || (ix >= 320) || (iy >= 240);
        if (m_oob) begin
            m_spd = 0;
            e.lat = 5;
        end else begin
            m_addr = iy * 320 + ix;
            t = terrain(m_addr, mode);
            e.lat = 6;
            if (t == 4'd0) m_spd = 0;
            else begin
                m_px = cx; m_py = cy;
                if (t == 4'd1 && m_spd > 64) m_spd = 64;
            end
        end
        e.x = m_px >>> 6; e.y = m_py >>> 6; e.deg = m_deg; e.spd = m_spd; e.addr = m_addr; e.t0 = t0;
        sb.push_back(e);
    endtask

    // Monitor: every falling edge of busy is one completed update.
    always @(negedge clk) begin
        if (rst_n && busy_q && !busy) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_update: got busy fall at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("world_x", int'(world_x), mon_e.x);
                chk("world_y", int'(world_y), mon_e.y);
                chk("degree", int'(degree), mon_e.deg);
                chk("speed", int'(speed), mon_e.spd);
                chk("map_addr", int'(map_addr), mon_e.addr);
                chk("latency", cyc - mon_e.t0, mon_e.lat);
            end
        end
        busy_q <= busy;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++; bad++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic do_tick(input bit a, input bit b, input bit l, input bit r, input bit extra);
        @(negedge clk);
        btn_accel = a; btn_brake = b; btn_left = l; btn_right = r;
        tick = 1'b1;
        model_tick(a, b, l, r, cyc);
        @(negedge clk);
        tick = 1'b0;
        if (extra) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
        end
        wait_idle();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_x"}, int'(world_x), START_X);
        chk({tag, "_y"}, int'(world_y), START_Y);
        chk({tag, "_deg"}, int'(degree), START_DEG);
        chk({tag, "_speed"}, int'(speed), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_addr"}, int'(map_addr), 0);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no finish within 60000 cycles, expected finish");
        $fatal(1);
    end

    initial begin
        int wx, rises, n;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_reset("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Straight-line acceleration on track.
        mode = 0;
        for (int i = 0; i < 10; i++) do_tick(1, 0, 0, 0, 0);
        chk("accel_x", int'(world_x), 43);
        chk("accel_y", int'(world_y), 40);
        chk("accel_speed", int'(speed), 40);

        // Heading wrap both ways, and both buttons held.
        do_tick(0, 0, 1, 0, 0);
        chk("left_wrap", int'(degree), 355);
        do_tick(0, 0, 0, 1, 0);
        chk("right_wrap", int'(degree), 0);
        do_tick(0, 0, 1, 1, 0);
        chk("both_held", int'(degree), 0);

        // Stop, build speed to 100, then hit a wall.
        while (m_spd > 0) do_tick(0, 1, 0, 0, 0);
        for (int i = 0; i < 25; i++) do_tick(1, 0, 0, 0, 0);
        chk("speed_100", int'(speed), 100);
        wx = int'(world_x);
        mode = 1;
        do_tick(1, 0, 0, 0, 0);
        chk("wall_x", int'(world_x), wx);
        chk("wall_speed", int'(speed), 0);

        // Build speed to 100 again, then drive onto grass.
        mode = 0;
        for (int i = 0; i < 25; i++) do_tick(1, 0, 0, 0, 0);
        wx = int'(world_x);
        mode = 2;
        do_tick(1, 0, 0, 0, 0);
        chk("grass_speed", int'(speed), 64);
        chk("grass_moved", (int'(world_x) > wx) ? 1 : 0, 1);

        // A second tick while busy is dropped.
        mode = 0;
        do_tick(1, 0, 0, 0, 1);
        rises = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy) rises++;
        end
        chk("dropped_tick_busy", rises, 0);
        chk("dropped_tick_updates", sb.size(), 0);

        // Reset asserted while the update waits on the map.
        @(negedge clk);
        btn_accel = 1'b1; btn_brake = 1'b0; btn_left = 1'b1; btn_right = 1'b0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("inflight_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        sb.delete();
        model_reset();
        #1 check_reset("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Drive east until the candidate leaves the map.
        mode = 0;
        n = 0;
        m_oob = 0;
        while (!m_oob && n < 300) begin
            do_tick(1, 0, 0, 0, 0);
            n++;
        end
        if (!m_oob) begin
            total++; bad++;
            $display("FAIL oob_reach: got no out-of-bounds after %0d ticks, expected one", n);
        end
        chk("oob_speed", int'(speed), 0);
        chk("oob_y", int'(world_y), 40);

        // Random driving over a patchwork map.
        mode = 3;
        for (int i = 0; i < 200; i++) begin
            bit a, b, l, r, x;
            a = ($urandom_range(0, 9) < 7);
            b = ($urandom_range(0, 9) == 0);
            l = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) == 0);
            x = ($urandom_range(0, 7) == 0);
            do_tick(a, b, l, r, x);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
